// File: rtl/countdown_timer_hms.sv
// BCD HH:MM:SS countdown timer with load validation, pause/resume and a timed alarm.
// Outputs use the clock's packed BCD format and feed the 7-segment decoders directly.
module countdown_timer_hms #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic [7:0] preset_h,
  input  logic [7:0] preset_m,
  input  logic [7:0] preset_s,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] qout_h,
  output logic [7:0] qout_m,
  output logic [7:0] qout_s,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t        state, state_n;
  logic [DW-1:0] h_n, m_n, s_n;
  logic [CW-1:0] acnt, acnt_n;
  logic          running_n, done_n, alarm_n, load_err_n;

  logic [3:0]    ns1, ns10, nm1, nm10, nh1, nh10;
  logic          bs0, bs1, bm0, bm1, bh;
  logic [DW-1:0] dec_h_c, dec_m_c, dec_s_c;
  logic          count_zero_c, dec_zero_c, preset_ok_c;

  // One-second decrement with borrow rippling from seconds up to hour tens.
  always_comb begin
    bs0  = (qout_s[3:0] == 4'd0);
    ns1  = bs0 ? 4'd9 : qout_s[3:0] - 4'd1;
    ns10 = bs0 ? ((qout_s[7:4] == 4'd0) ? 4'd5 : qout_s[7:4] - 4'd1) : qout_s[7:4];
    bs1  = bs0 && (qout_s[7:4] == 4'd0);
    nm1  = bs1 ? ((qout_m[3:0] == 4'd0) ? 4'd9 : qout_m[3:0] - 4'd1) : qout_m[3:0];
    bm0  = bs1 && (qout_m[3:0] == 4'd0);
    nm10 = bm0 ? ((qout_m[7:4] == 4'd0) ? 4'd5 : qout_m[7:4] - 4'd1) : qout_m[7:4];
    bm1  = bm0 && (qout_m[7:4] == 4'd0);
    nh1  = bm1 ? ((qout_h[3:0] == 4'd0) ? 4'd9 : qout_h[3:0] - 4'd1) : qout_h[3:0];
    bh   = bm1 && (qout_h[3:0] == 4'd0);
    nh10 = bh ? qout_h[7:4] - 4'd1 : qout_h[7:4];
    dec_h_c      = {nh10, nh1};
    dec_m_c      = {nm10, nm1};
    dec_s_c      = {ns10, ns1};
    count_zero_c = ({qout_h, qout_m, qout_s} == 24'h000000);
    dec_zero_c   = ({dec_h_c, dec_m_c, dec_s_c} == 24'h000000);
  end

  // Preset is a legal time of day in BCD.
  always_comb begin
    preset_ok_c = (preset_h[3:0] <= 4'd9) && (preset_h <= 8'h23) &&
                  (preset_m[3:0] <= 4'd9) && (preset_m[7:4] <= 4'd5) &&
                  (preset_s[3:0] <= 4'd9) && (preset_s[7:4] <= 4'd5);
  end

  // Next-state and next-output logic; priority load > start > pause > tick.
  always_comb begin
    state_n    = state;
    h_n        = qout_h;
    m_n        = qout_m;
    s_n        = qout_s;
    acnt_n     = acnt;
    done_n     = 1'b0;
    load_err_n = 1'b0;
    if (load) begin
      if (preset_ok_c) begin
        state_n = IDLE;
        h_n     = preset_h;
        m_n     = preset_m;
        s_n     = preset_s;
        acnt_n  = '0;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (start) begin
      case (state)
        IDLE, PAUSE: if (!count_zero_c) state_n = RUN;
        ALARM: begin
          state_n = IDLE;
          acnt_n  = '0;
        end
        default: ;
      endcase
    end else if (pause) begin
      if (state == RUN) state_n = PAUSE;
    end else if (tick_1hz) begin
      case (state)
        RUN: if (!count_zero_c) begin
          h_n = dec_h_c;
          m_n = dec_m_c;
          s_n = dec_s_c;
          if (dec_zero_c) begin
            state_n = ALARM;
            done_n  = 1'b1;
            acnt_n  = '0;
          end
        end
        ALARM: begin
          if (acnt == CW'(ALARM_SECS - 1)) begin
            state_n = IDLE;
            acnt_n  = '0;
          end else begin
            acnt_n = acnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
    running_n = (state_n == RUN);
    alarm_n   = (state_n == ALARM);
  end

  // State, count and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      qout_h   <= '0;
      qout_m   <= '0;
      qout_s   <= '0;
      acnt     <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      qout_h   <= h_n;
      qout_m   <= m_n;
      qout_s   <= s_n;
      acnt     <= acnt_n;
      running  <= running_n;
      done     <= done_n;
      alarm    <= alarm_n;
      load_err <= load_err_n;
    end
  end

endmodule

// File: doc/countdown_timer_hms.md
Name: countdown_timer_hms

Overview:
BCD countdown timer for the digital clock: counts HH:MM:SS down from a loaded preset to 00:00:00, one step per 1 Hz tick. It is the down-counting counterpart of the clock's up-counting hour/minute/second chain. It borrows across second, minute and hour digits. At zero it raises a timed alarm. Outputs use the same 8-bit packed BCD format as the clock counters, so they drive the existing 7-segment decoders directly.

Parameters:
ALARM_SECS, 10, number of tick_1hz pulses the alarm output stays high after reaching zero (1..255).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
tick_1hz  input  1  one-clk-wide enable, one pulse per second
load  input  1  one-clk pulse; captures preset_h/m/s
preset_h  input  8  BCD hours preset, [7:4] tens, [3:0] ones, valid 00..23
preset_m  input  8  BCD minutes preset, valid 00..59
preset_s  input  8  BCD seconds preset, valid 00..59
start  input  1  one-clk pulse; begin/resume counting
pause  input  1  one-clk pulse; suspend counting
qout_h  output  8  current hours, BCD
qout_m  output  8  current minutes, BCD
qout_s  output  8  current seconds, BCD
running  output  1  high in RUN state
done  output  1  one-clk pulse on reaching 00:00:00
alarm  output  1  high while in ALARM state
load_err  output  1  one-clk pulse when a load is rejected

Behaviour:
- Reset (asynchronous, active-high):
  - qout_h/m/s = 8'h00; state = IDLE.
  - running, done, alarm, load_err = 0.
  - Alarm tick counter = 0.
- All other logic is synchronous to posedge clk; all outputs are registered.
- States: IDLE, RUN, PAUSE, ALARM.
- Priority within a cycle: load > start > pause > tick_1hz.
- Load (any state):
  - Each BCD digit must be <=9, tens of minutes/seconds <=5, hours <=8'h23.
  - Valid: count <= preset next edge; state -> IDLE; alarm cleared.
  - Invalid: count unchanged; state unchanged; load_err = 1 for one cycle.
- Start:
  - From IDLE or PAUSE with count != 0: -> RUN.
  - With count == 0: ignored.
  - In RUN: no effect.
  - In ALARM: clears alarm and goes to IDLE; count stays 0.
- Pause:
  - RUN -> PAUSE.
  - Ignored in every other state.
- Tick in RUN, decrement one second:
  - s_ones: 0 -> 9 with borrow, else -1.
  - s_tens: 0 -> 5 with borrow when borrowed into, else -1.
  - Minutes digits follow the same rules as seconds.
  - h_ones: 0 -> 9 with borrow to h_tens.
  - h_tens only decrements when borrowed into.
  - The count never wraps past 00:00:00.
- Zero reached:
  - On the tick where count == 00:00:01, count becomes 00:00:00 and state -> ALARM at the same edge.
  - done = 1 for exactly that one cycle; alarm = 1 from that edge.
- ALARM:
  - Counts tick_1hz pulses.
  - After ALARM_SECS ticks, alarm -> 0 and state -> IDLE at that edge.
  - Reset, load or start exits ALARM immediately.
- Ticks outside RUN are ignored; count is frozen in PAUSE.
- Simultaneous load + tick in RUN: load wins; no decrement that cycle.
- Simultaneous pause + tick in RUN: pause wins; no decrement.
- running = (state == RUN), registered alongside the state.
- Reset asserted mid-count returns immediately to 00:00:00 IDLE; no done pulse is generated.

Test Plan:
1. Reset, load 00:00:03, start, 3 ticks -> counts 02, 01, 00; done pulses once on the 3rd tick's edge; alarm high; after 10 more ticks alarm=0, state IDLE.
2. Load 01:00:00, start, 1 tick -> 00:59:59; load 10:00:00, start, 1 tick -> 09:59:59 (full borrow chain across all digits).
3. Load 00:00:10, start, 2 ticks, pause, 5 ticks -> holds 00:00:08, running=0; start, 1 tick -> 00:00:07.
4. Load preset_m=8'h60, then separately load preset_h=8'h24 -> load_err pulses each time; count keeps its prior value; state unchanged.
5. Count zero, start -> stays IDLE, no done. During ALARM, start -> alarm drops next edge. Load and tick in the same cycle while RUN at 00:00:05 -> count = new preset with no decrement.
6. Assert reset asynchronously mid-RUN at 12:34:56 -> outputs 00:00:00, running=0, alarm=0 immediately; no done pulse.
